// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Tracks FIFO occupancy with its own credit counter so a registered write never lands in a full FIFO.
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              gnt,
  output logic                         wr_enb,
  output logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_enb,
  input  logic                         empty,
  input  logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   credit_cnt,
  output logic                         ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] cand;
  logic          found;
  logic          space;
  logic          grant;
  logic          rd_fire;
  int            idx;

  // Lowest offset from ptr wins, so scan offsets from the top down and let later hits overwrite.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[PW'(idx)]) begin
        found = 1'b1;
        cand  = PW'(idx);
      end
    end
  end

  // Space looks only at the registered count, keeping rd_enb/empty out of the grant path.
  assign space   = (cnt < CW'(DEPTH));
  assign grant   = found & space & ~rst;
  assign rd_fire = rd_enb & ~empty;

  always_comb begin
    gnt = '0;
    if (grant) gnt[cand] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      wr_enb  <= 1'b0;
      wr_data <= '0;
      ovf_err <= 1'b0;
    end else begin
      wr_enb <= grant;
      if (grant) begin
        ptr     <= (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
        wr_data <= req_data[cand*WIDTH +: WIDTH];
      end
      // A read with cnt already at zero is a producer-side protocol error; saturate silently.
      case ({grant, rd_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (overflow) ovf_err <= 1'b1;
    end
  end

  assign credit_cnt = cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a behavioural model predicts grants and writes,
// a separate monitor pops expected write data whenever the DUT raises wr_enb.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WIDTH-1:0]  req_data = '0;
  logic [NREQ-1:0]        gnt;
  logic                   wr_enb;
  logic [WIDTH-1:0]       wr_data;
  logic                   rd_enb = 1'b0;
  logic                   empty = 1'b1;
  logic                   overflow = 1'b0;
  logic [CW-1:0]          credit_cnt;
  logic                   ovf_err;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] slot_data[NREQ];
  bit               hold_data = 1'b0;

  int               m_ptr  = 0;
  int               m_cnt  = 0;
  int               m_fifo = 0;
  bit               m_wr   = 1'b0;
  bit               m_ovf  = 1'b0;
  logic [WIDTH-1:0] m_wd   = '0;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .wr_enb     (wr_enb),
    .wr_data    (wr_data),
    .rd_enb     (rd_enb),
    .empty      (empty),
    .overflow   (overflow),
    .credit_cnt (credit_cnt),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every write the DUT issues must match the oldest predicted write.
  always @(negedge clk) begin
    if (wr_enb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'(wr_data), 32'hFFFF_FFFF);
      end else begin
        checkOutput("wr_data_sb", 32'(wr_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock cycle: drive inputs, predict and check grant, advance the model, check registered outputs.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input bit rd, input bit emp,
                               input bit ovf, input bit rs);
    int  cand;
    bit  found;
    bit  g;
    bit  fire;
    @(negedge clk);
    req = r;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = slot_data[i];
    rd_enb   = rd;
    empty    = emp;
    overflow = ovf;
    rst      = rs;

    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && r[(m_ptr + k) % NREQ]) begin
        found = 1'b1;
        cand  = (m_ptr + k) % NREQ;
      end
    end
    g    = found && (m_cnt < DEPTH) && !rs;
    fire = rd && !emp;

    #1;
    checkOutput("gnt", 32'(gnt), g ? (32'd1 << cand) : 32'd0);
    if (g) exp_q.push_back(slot_data[cand]);

    @(posedge clk);
    if (rs) begin
      m_ptr = 0; m_cnt = 0; m_fifo = 0; m_wr = 1'b0; m_wd = '0; m_ovf = 1'b0;
    end else begin
      m_fifo = m_fifo + int'(m_wr) - ((fire && m_fifo > 0) ? 1 : 0);
      if (g) begin
        m_ptr = (cand + 1) % NREQ;
        m_wd  = slot_data[cand];
        if (!hold_data) slot_data[cand] = WIDTH'($urandom);
      end
      m_cnt = m_cnt + int'(g) - int'(fire);
      if (m_cnt < 0) m_cnt = 0;
      m_wr = g;
      if (ovf) m_ovf = 1'b1;
    end

    #1;
    checkOutput("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
    checkOutput("wr_enb", 32'(wr_enb), 32'(m_wr));
    checkOutput("wr_data", 32'(wr_data), 32'(m_wd));
    checkOutput("ovf_err", 32'(ovf_err), 32'(m_ovf));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) slot_data[i] = WIDTH'($urandom);

    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Single requester fill with constant data; grants must stop at DEPTH.
    hold_data    = 1'b1;
    slot_data[2] = 8'hA5;
    repeat (20) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_data = 1'b0;

    // Full with simultaneous read: no grant this cycle, freed slot used next cycle.
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Round-robin with continuous draining, then with requester 1 dropped.
    repeat (14) applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9)  applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);

    // Drain to zero, then reads while empty and reads past zero.
    repeat (18) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2)  applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Build ptr=2, cnt=7, then reset mid-operation with all requesting.
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_cnt", 32'(credit_cnt), 32'd7);
    repeat (2) applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sticky overflow flag, cleared only by reset.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (22) applyStimulus(4'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic with empty derived from the modelled FIFO occupancy.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(4'($urandom), ($urandom_range(0, 2) != 0), (m_fifo == 0),
                    ($urandom_range(0, 99) == 0), ($urandom_range(0, 79) == 0));
    end

    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO among NREQ producers. It sits between the producers and the FIFO's wr_enb/wr_data inputs. It keeps its own credit counter of FIFO occupancy, so it never issues a write into a full FIFO despite its one-cycle registered output stage. It also snoops the FIFO read side and flags any FIFO overflow.

## Interface

Parameters:
- WIDTH, 8, data width; must match the FIFO data width
- DEPTH, 16, FIFO depth in entries; must match the FIFO instance
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- req  input  NREQ  per-requester write request
- req_data  input  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, combinational, same cycle as acceptance
- wr_enb  output  1  registered write enable to FIFO
- wr_data  output  WIDTH  registered write data to FIFO
- rd_enb  input  1  FIFO read enable (snooped, same net that drives FIFO)
- empty  input  1  FIFO empty flag
- overflow  input  1  FIFO overflow flag
- credit_cnt  output  $clog2(DEPTH+1)  arbiter's view of FIFO occupancy, including the write in flight
- ovf_err  output  1  sticky: FIFO reported overflow

## Operation

- State: rotating pointer ptr (0..NREQ-1); counter cnt (0..DEPTH); output regs wr_enb, wr_data; ovf_err.
- Selection: scan req from index ptr upward, wrapping modulo NREQ. The first set bit is the candidate.
- Space: space = (cnt < DEPTH), evaluated on the registered cnt only.
- Grant: gnt[cand] = 1 iff a candidate exists, space is true and rst = 0. Otherwise gnt = 0.
- Pointer: on grant, ptr <= (cand+1) mod NREQ. With no grant, ptr holds.
- Write issue: on grant, wr_enb <= 1 and wr_data <= req_data slice of cand. Otherwise wr_enb <= 0 and wr_data holds.
- Read fire: rd_fire = rd_enb & ~empty.
- Counter: cnt <= cnt + grant - rd_fire.
  - Grant and rd_fire together leave cnt unchanged.
  - rd_fire with cnt = 0 leaves cnt at 0 (saturating; protocol error, no flag).
- Full plus simultaneous read: with cnt = DEPTH, no grant is issued in that cycle even if rd_fire = 1. The freed slot is usable the following cycle.
- Producer rule: a requester holds req and its data stable until it sees gnt at a clock edge. After that edge it may drop req or present new data.
- Overflow: overflow = 1 at any edge sets ovf_err = 1. ovf_err clears only on rst.
- Reset, applied on the edge where rst = 1:
  - ptr = 0, cnt = 0, wr_enb = 0, wr_data = 0, ovf_err = 0.
  - gnt is forced to 0 while rst is high.
  - A grant given in the cycle before rst rises is not issued: wr_enb = 0 after the reset edge. The FIFO is reset together with the arbiter.

## Timing

- Grant-to-write latency: 1 cycle. gnt in cycle N gives wr_enb/wr_data valid in cycle N+1.
- Throughput: one write per cycle while space holds. Back-to-back grants to different requesters are allowed.
- credit_cnt reflects the grant immediately after the edge, one cycle before the FIFO itself counts the entry. It never exceeds DEPTH.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once every NREQ grants.
- gnt has a combinational path from req, ptr and cnt. There is no combinational path from rd_enb or empty to gnt.

## Test plan

- **Single requester fill:** req[2] = 1 with data 0xA5 from reset, no reads. Required: gnt[2] every cycle for 16 cycles, wr_enb = 1 with wr_data = 0xA5 for 16 cycles starting one cycle later, credit_cnt climbs to 16, then gnt = 0 and wr_enb = 0; the FIFO must never assert overflow.
- **Round-robin order:** req = 4'b1111 held, FIFO drained every cycle (rd_enb = 1, empty = 0). Required: grant sequence 0,1,2,3,0,1…; after req[1] drops, the sequence is 0,2,3,0,2,3.
- **Full with read:** cnt = 16, req[0] = 1, rd_enb = 1, empty = 0 for one cycle. Required: no gnt that cycle, cnt = 15 after the edge, gnt[0] on the next cycle, cnt back to 16.
- **Read while empty:** rd_enb = 1 and empty = 1 with cnt = 0. Required: cnt stays 0, no change in gnt.
- **Mid-operation reset:** ptr = 2, cnt = 7, req = 4'b1111, rst high for 2 cycles. Required: gnt = 0 during reset; wr_enb, credit_cnt and ovf_err all 0; the first grant after release goes to requester 0.
- **Overflow flag:** overflow pulsed for one cycle. Required: ovf_err = 1 from the next edge and held for 20+ cycles until rst.
